// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-stage WEN/flush, PC enable, sticky halt and a stall counter.
// Controls are combinational from state and inputs; halted and stall_count are registered.
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             id_jump,
   input  logic             ex_MemRead,
   input  logic [4:0]       ex_rt,
   input  logic             mem_MemRead,
   input  logic             mem_MemWrite,
   input  logic             mem_branch_taken,
   input  logic             mem_halt,
   output logic             pc_WEN,
   output logic             ifid_WEN,
   output logic             ifid_flush,
   output logic             idex_WEN,
   output logic             idex_flush,
   output logic             exmem_WEN,
   output logic             exmem_flush,
   output logic             memwb_WEN,
   output logic             memwb_flush,
   output logic             halted,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

   state_t           state_q, state_d;
   logic             halted_q, halted_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   logic memop, lduse;
   logic pc_wen_c, ifid_wen_c, ifid_flush_c, idex_wen_c, idex_flush_c;
   logic exmem_wen_c, exmem_flush_c, memwb_wen_c, memwb_flush_c;

   assign memop = mem_MemRead | mem_MemWrite;
   assign lduse = ex_MemRead && (ex_rt != 5'd0) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

   always_comb begin
      pc_wen_c      = 1'b1;
      ifid_wen_c    = 1'b1;
      ifid_flush_c  = 1'b0;
      idex_wen_c    = 1'b1;
      idex_flush_c  = 1'b0;
      exmem_wen_c   = 1'b1;
      exmem_flush_c = 1'b0;
      memwb_wen_c   = 1'b1;
      memwb_flush_c = 1'b0;
      state_d       = state_q;

      if (state_q == HALT) begin
         pc_wen_c    = 1'b0;
         ifid_wen_c  = 1'b0;
         idex_wen_c  = 1'b0;
         exmem_wen_c = 1'b0;
         memwb_wen_c = 1'b0;
      end else if (memop && !dhit) begin
         // Freeze the front; MEM/WB takes a bubble so the stalled op is not written back twice.
         pc_wen_c      = 1'b0;
         ifid_wen_c    = 1'b0;
         idex_wen_c    = 1'b0;
         exmem_wen_c   = 1'b0;
         memwb_flush_c = 1'b1;
         state_d       = DWAIT;
      end else begin
         state_d = RUN;
         if (mem_halt && !memop) begin
            pc_wen_c    = 1'b0;
            ifid_wen_c  = 1'b0;
            idex_wen_c  = 1'b0;
            exmem_wen_c = 1'b0;
            state_d     = HALT;
         end else if (mem_branch_taken) begin
            ifid_flush_c  = 1'b1;
            idex_flush_c  = 1'b1;
            exmem_flush_c = 1'b1;
         end else if (lduse) begin
            pc_wen_c     = 1'b0;
            ifid_wen_c   = 1'b0;
            idex_flush_c = 1'b1;
         end else if (id_jump) begin
            ifid_flush_c = 1'b1;
         end else if (!ihit) begin
            pc_wen_c     = 1'b0;
            ifid_flush_c = 1'b1;
         end
      end

      halted_d      = (state_d == HALT);
      stall_count_d = stall_count_q;
      if (state_q != HALT && !pc_wen_c && stall_count_q != {CNT_W{1'b1}})
         stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q       <= RUN;
         halted_q      <= 1'b0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         halted_q      <= halted_d;
         stall_count_q <= stall_count_d;
      end
   end

   // Reset forces every control low regardless of the registered state.
   assign pc_WEN      = nRST & pc_wen_c;
   assign ifid_WEN    = nRST & ifid_wen_c;
   assign ifid_flush  = nRST & ifid_flush_c;
   assign idex_WEN    = nRST & idex_wen_c;
   assign idex_flush  = nRST & idex_flush_c;
   assign exmem_WEN   = nRST & exmem_wen_c;
   assign exmem_flush = nRST & exmem_flush_c;
   assign memwb_WEN   = nRST & memwb_wen_c;
   assign memwb_flush = nRST & memwb_flush_c;
   assign halted      = halted_q;
   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Table-driven bench for hazard_ctrl: expected controls/counters queued per driven cycle.
module tb_hazard_ctrl;

   localparam int CW = 4;

   // {pc, ifid_W, ifid_F, idex_W, idex_F, exmem_W, exmem_F, memwb_W, memwb_F}
   localparam logic [8:0] C_RUN = 9'b110101010;
   localparam logic [8:0] C_LDU = 9'b000111010;
   localparam logic [8:0] C_DW  = 9'b000000011;
   localparam logic [8:0] C_BR  = 9'b111111110;
   localparam logic [8:0] C_JMP = 9'b111101010;
   localparam logic [8:0] C_NOI = 9'b011101010;
   localparam logic [8:0] C_HLT = 9'b000000010;
   localparam logic [8:0] C_OFF = 9'b000000000;

   typedef struct {
      logic nr, ih, dh, mr, mw, br, jp, hl, exr, urt;
      logic [4:0] exrt, rs, rt;
   } in_t;

   typedef struct {
      logic [8:0]    ctl;
      logic [CW-1:0] cnt;
      logic          hlt;
   } exp_t;

   logic CLK = 1'b0;
   logic nRST = 1'b0;
   logic ihit = 1'b0, dhit = 1'b0, id_uses_rt = 1'b0, id_jump = 1'b0, ex_MemRead = 1'b0;
   logic mem_MemRead = 1'b0, mem_MemWrite = 1'b0, mem_branch_taken = 1'b0, mem_halt = 1'b0;
   logic [4:0] id_rs = 5'd0, id_rt = 5'd0, ex_rt = 5'd0;
   logic pc_WEN, ifid_WEN, ifid_flush, idex_WEN, idex_flush;
   logic exmem_WEN, exmem_flush, memwb_WEN, memwb_flush, halted;
   logic [CW-1:0] stall_count;
   logic [8:0] ctl_o;

   int checks = 0;
   int errors = 0;

   in_t  tab_s[$];
   exp_t tab_e[$];
   exp_t exp_q[$];

   always #5 CLK = ~CLK;

   hazard_ctrl #(.CNT_W(CW)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
      .ex_MemRead(ex_MemRead), .ex_rt(ex_rt),
      .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
      .mem_branch_taken(mem_branch_taken), .mem_halt(mem_halt),
      .pc_WEN(pc_WEN), .ifid_WEN(ifid_WEN), .ifid_flush(ifid_flush),
      .idex_WEN(idex_WEN), .idex_flush(idex_flush),
      .exmem_WEN(exmem_WEN), .exmem_flush(exmem_flush),
      .memwb_WEN(memwb_WEN), .memwb_flush(memwb_flush),
      .halted(halted), .stall_count(stall_count)
   );

   assign ctl_o = {pc_WEN, ifid_WEN, ifid_flush, idex_WEN, idex_flush,
                   exmem_WEN, exmem_flush, memwb_WEN, memwb_flush};

   function automatic in_t st(input logic nr, ih, dh, mr, mw, br, jp, hl, exr,
                              input logic [4:0] exrt, rs, rt, input logic urt);
      in_t s;
      s.nr = nr; s.ih = ih; s.dh = dh; s.mr = mr; s.mw = mw; s.br = br;
      s.jp = jp; s.hl = hl; s.exr = exr; s.exrt = exrt; s.rs = rs; s.rt = rt; s.urt = urt;
      return s;
   endfunction

   function automatic in_t idle();
      return st(1, 1, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
   endfunction

   function automatic in_t in_rst();
      return st(0, 1, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
   endfunction

   task automatic add(input in_t s, input logic [8:0] ctl, input int cnt, input logic hlt);
      exp_t e;
      e.ctl = ctl; e.cnt = CW'(cnt); e.hlt = hlt;
      tab_s.push_back(s);
      tab_e.push_back(e);
   endtask

   task automatic apply(input in_t s);
      nRST = s.nr; ihit = s.ih; dhit = s.dh; mem_MemRead = s.mr; mem_MemWrite = s.mw;
      mem_branch_taken = s.br; id_jump = s.jp; mem_halt = s.hl; ex_MemRead = s.exr;
      ex_rt = s.exrt; id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.urt;
   endtask

   task automatic test_reset();
      exp_t e;
      int   i = 0;
      add(in_rst(), C_OFF, 0, 0);
      add(in_rst(), C_OFF, 0, 0);
      add(idle(),   C_RUN, 0, 0);
      add(idle(),   C_RUN, 0, 0);
      while (tab_s.size() > 0) begin
         apply(tab_s.pop_front());
         exp_q.push_back(tab_e.pop_front());
         #1;
         e = exp_q.pop_front();
         checks++;
         if (ctl_o !== e.ctl || stall_count !== e.cnt || halted !== e.hlt) begin
            errors++;
            $display("FAIL reset[%0d]: got ctl=%b cnt=%0d halted=%b, want ctl=%b cnt=%0d halted=%b",
                     i, ctl_o, stall_count, halted, e.ctl, e.cnt, e.hlt);
         end
         @(negedge CLK);
         i++;
      end
   endtask

   task automatic test_load_use();
      exp_t e;
      int   i = 0;
      add(in_rst(), C_OFF, 0, 0);
      add(st(1, 1, 0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0), C_LDU, 0, 0);
      add(idle(), C_RUN, 1, 0);
      add(st(1, 1, 0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1), C_RUN, 1, 0);
      add(st(1, 1, 0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 1), C_LDU, 1, 0);
      add(st(1, 1, 0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 0), C_RUN, 2, 0);
      add(st(1, 1, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd7, 5'd7, 1), C_RUN, 2, 0);
      while (tab_s.size() > 0) begin
         apply(tab_s.pop_front());
         exp_q.push_back(tab_e.pop_front());
         #1;
         e = exp_q.pop_front();
         checks++;
         if (ctl_o !== e.ctl || stall_count !== e.cnt || halted !== e.hlt) begin
            errors++;
            $display("FAIL load_use[%0d]: got ctl=%b cnt=%0d halted=%b, want ctl=%b cnt=%0d halted=%b",
                     i, ctl_o, stall_count, halted, e.ctl, e.cnt, e.hlt);
         end
         @(negedge CLK);
         i++;
      end
   endtask

   task automatic test_data_wait();
      exp_t e;
      int   i = 0;
      add(in_rst(), C_OFF, 0, 0);
      add(st(1, 1, 0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_DW,  0, 0);
      add(st(1, 1, 0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_DW,  1, 0);
      add(st(1, 1, 0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_DW,  2, 0);
      add(st(1, 1, 1, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_RUN, 3, 0);
      add(idle(), C_RUN, 3, 0);
      add(st(1, 1, 0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_DW,  3, 0);
      add(st(1, 0, 1, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_NOI, 4, 0);
      add(idle(), C_RUN, 5, 0);
      add(st(1, 1, 0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_DW,  5, 0);
      add(idle(), C_RUN, 6, 0);
      add(st(1, 1, 1, 1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_BR,  6, 0);
      add(st(1, 1, 0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_DW,  6, 0);
      add(st(0, 1, 0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_OFF, 0, 0);
      add(st(1, 1, 1, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_RUN, 0, 0);
      while (tab_s.size() > 0) begin
         apply(tab_s.pop_front());
         exp_q.push_back(tab_e.pop_front());
         #1;
         e = exp_q.pop_front();
         checks++;
         if (ctl_o !== e.ctl || stall_count !== e.cnt || halted !== e.hlt) begin
            errors++;
            $display("FAIL data_wait[%0d]: got ctl=%b cnt=%0d halted=%b, want ctl=%b cnt=%0d halted=%b",
                     i, ctl_o, stall_count, halted, e.ctl, e.cnt, e.hlt);
         end
         @(negedge CLK);
         i++;
      end
   endtask

   task automatic test_branch_jump();
      exp_t e;
      int   i = 0;
      add(in_rst(), C_OFF, 0, 0);
      add(st(1, 1, 0, 0, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_BR,  0, 0);
      add(st(1, 1, 0, 0, 0, 1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0), C_BR,  0, 0);
      add(st(1, 1, 0, 0, 0, 0, 1, 0, 1, 5'd5, 5'd5, 5'd0, 0), C_LDU, 0, 0);
      add(st(1, 0, 0, 0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_JMP, 1, 0);
      add(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_NOI, 1, 0);
      add(st(1, 0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 0), C_LDU, 2, 0);
      add(idle(), C_RUN, 3, 0);
      add(st(1, 1, 0, 1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_DW,  3, 0);
      add(st(1, 1, 1, 1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_BR,  4, 0);
      while (tab_s.size() > 0) begin
         apply(tab_s.pop_front());
         exp_q.push_back(tab_e.pop_front());
         #1;
         e = exp_q.pop_front();
         checks++;
         if (ctl_o !== e.ctl || stall_count !== e.cnt || halted !== e.hlt) begin
            errors++;
            $display("FAIL branch_jump[%0d]: got ctl=%b cnt=%0d halted=%b, want ctl=%b cnt=%0d halted=%b",
                     i, ctl_o, stall_count, halted, e.ctl, e.cnt, e.hlt);
         end
         @(negedge CLK);
         i++;
      end
   endtask

   task automatic test_halt();
      exp_t e;
      int   i = 0;
      add(in_rst(), C_OFF, 0, 0);
      add(st(1, 1, 0, 0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0), C_HLT, 0, 0);
      for (int k = 0; k < 10; k++)
         add(st(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0,
                5'd0, 5'd0, 5'd0, 0), C_OFF, 1, 1);
      add(st(0, 1, 0, 0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0), C_OFF, 0, 0);
      add(idle(), C_RUN, 0, 0);
      add(idle(), C_RUN, 0, 0);
      while (tab_s.size() > 0) begin
         apply(tab_s.pop_front());
         exp_q.push_back(tab_e.pop_front());
         #1;
         e = exp_q.pop_front();
         checks++;
         if (ctl_o !== e.ctl || stall_count !== e.cnt || halted !== e.hlt) begin
            errors++;
            $display("FAIL halt[%0d]: got ctl=%b cnt=%0d halted=%b, want ctl=%b cnt=%0d halted=%b",
                     i, ctl_o, stall_count, halted, e.ctl, e.cnt, e.hlt);
         end
         @(negedge CLK);
         i++;
      end
   endtask

   task automatic test_saturation();
      exp_t e;
      int   i = 0;
      add(in_rst(), C_OFF, 0, 0);
      for (int k = 0; k < 20; k++)
         add(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0), C_NOI, (k > 15) ? 15 : k, 0);
      add(idle(), C_RUN, 15, 0);
      while (tab_s.size() > 0) begin
         apply(tab_s.pop_front());
         exp_q.push_back(tab_e.pop_front());
         #1;
         e = exp_q.pop_front();
         checks++;
         if (ctl_o !== e.ctl || stall_count !== e.cnt || halted !== e.hlt) begin
            errors++;
            $display("FAIL saturation[%0d]: got ctl=%b cnt=%0d halted=%b, want ctl=%b cnt=%0d halted=%b",
                     i, ctl_o, stall_count, halted, e.ctl, e.cnt, e.hlt);
         end
         @(negedge CLK);
         i++;
      end
   endtask

   initial begin
      @(negedge CLK);
      test_reset();
      test_load_use();
      test_data_wait();
      test_branch_jump();
      test_halt();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline controller: the producer side of the per-stage WEN/flush controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus PC enable.
- Resolves instruction/data memory waits, load-use hazards, taken branches (resolved in MEM), jumps (resolved in ID) and halt.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- CNT_W, 16, width of stall_count.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- ihit  input  1  instruction fetch for the current PC is complete this cycle.
- dhit  input  1  data access from the MEM stage is complete this cycle.
- id_rs  input  5  rs field of the instruction in ID.
- id_rt  input  5  rt field of the instruction in ID.
- id_uses_rt  input  1  ID instruction reads rt as a source.
- id_jump  input  1  ID holds j/jal/jr; PC is redirected this cycle.
- ex_MemRead  input  1  EX holds a load.
- ex_rt  input  5  destination register of the EX load.
- mem_MemRead  input  1  MEM holds a load.
- mem_MemWrite  input  1  MEM holds a store.
- mem_branch_taken  input  1  MEM holds a taken beq/bne.
- mem_halt  input  1  MEM holds halt.
- pc_WEN  output  1  PC update enable.
- ifid_WEN  output  1  IF/ID load enable.
- ifid_flush  output  1  IF/ID loads a NOP.
- idex_WEN  output  1  ID/EX load enable.
- idex_flush  output  1  ID/EX loads a NOP.
- exmem_WEN  output  1  EX/MEM load enable.
- exmem_flush  output  1  EX/MEM loads a NOP.
- memwb_WEN  output  1  MEM/WB load enable.
- memwb_flush  output  1  MEM/WB loads a NOP.
- halted  output  1  registered; sticky halt indication.
- stall_count  output  CNT_W  registered; saturating count of cycles with pc_WEN=0 while not halted.

Behaviour:
- Reset (nRST=0, asynchronous): state=RUN, halted=0, stall_count=0. While nRST=0, all *_WEN=0 and all *_flush=0.
- Control outputs are combinational from state and inputs. A flush is meaningful only together with WEN=1.
- "memop" = mem_MemRead | mem_MemWrite.
- "lduse" = ex_MemRead & ex_rt≠0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- States:
  - RUN: normal operation.
  - DWAIT: data access outstanding.
  - HALT: pipeline stopped.
- RUN/DWAIT output priority, highest first:
  1. memop & !dhit:
     - pc/ifid/idex/exmem WEN=0.
     - memwb_WEN=1, memwb_flush=1 (bubble; no duplicate writeback).
     - Next state=DWAIT.
  2. mem_branch_taken:
     - All WEN=1.
     - ifid_flush=idex_flush=exmem_flush=1.
     - PC loads branch target.
  3. lduse:
     - pc_WEN=ifid_WEN=0.
     - idex_WEN=1, idex_flush=1.
     - exmem_WEN=memwb_WEN=1.
  4. id_jump:
     - All WEN=1, ifid_flush=1.
     - PC redirect does not wait on ihit.
  5. !ihit:
     - pc_WEN=0.
     - ifid_WEN=1, ifid_flush=1.
     - Remaining stages advance.
  6. Otherwise: all WEN=1, no flush.
- Any case with memop & dhit resolves via rules 2–6, and state returns to RUN.
- DWAIT holds until dhit. memop is guaranteed stable while frozen. If memop deasserts in DWAIT, return to RUN the same cycle.
- mem_halt in RUN with no memop (halt never carries a memop):
  - memwb_WEN=1 so the preceding writeback completes; all other WEN=0.
  - Next state=HALT; halted=1 from the next edge.
- HALT: all WEN=0, all flush=0. Exited only by reset. Ignores every input.
- stall_count increments on each edge where pc_WEN=0 and state≠HALT. Saturates at 2^CNT_W−1 (no wrap). Frozen in HALT.
- Simultaneous mem_branch_taken and id_jump: branch wins; the jump is flushed with ID.
- Reset asserted mid-DWAIT: immediate return to RUN, outputs forced per the reset rule.

Test Plan:
- Reset: nRST=0 with ihit=1 → all WEN=0, flush=0, stall_count=0. First cycle after release with ihit=1 and no hazard → all WEN=1.
- Load-use: ex_MemRead=1, ex_rt=5, id_rs=5, ihit=1 → pc_WEN=0, ifid_WEN=0, idex_flush=1 for 1 cycle; stall_count=1. Repeat with ex_rt=0 → no stall.
- Data wait: mem_MemRead=1, dhit=0 for 3 cycles then 1 → 3 cycles of frozen front, memwb_flush=1, state DWAIT; on dhit all advance; stall_count=3.
- Branch vs jump: mem_branch_taken=1 and id_jump=1 in the same cycle → ifid/idex/exmem flush=1, pc_WEN=1. Also branch with lduse active → branch wins, no idex-only bubble.
- Halt: mem_halt=1 → memwb_WEN=1 only; next cycle halted=1, all WEN=0 for 10 further cycles regardless of ihit/dhit; nRST pulse clears halted.
- Saturation: CNT_W=4, hold ihit=0 for 20 cycles → stall_count stops at 15.
